dmem_arbiter: RTL and testbench

Shares the single-port data memory between the core load/store path and a DMA/loader port. Arbitrates once per clock with core priority, bounded by a starvation counter that guarantees DMA progress. Drives the memory's read/write enables, address and write data, and returns registered read responses with an error flag to the granted requester. Sits between the core's memory stage, the DMA engine and the data memory.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_starve_ctr.sv | 41 ++++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// grant-select codes, response record and the default starvation limit.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB     = 1'b0,
        FORCE_D = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_C    = 2'd1,
        SEL_D    = 2'd2
    } port_sel_e;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned CTR_W            = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating DMA starvation counter; hit flags that the count is about to
// reach the limit, so the arbiter can force the DMA on the very next cycle.
module dmem_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [CTR_W-1:0] LIMIT = CTR_W'(STARVE_LIMIT);

    logic [CTR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: assign a default before any branch so the combinational block cannot infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Looking at the next value lets the FSM switch at the same edge the limit is reached.
    assign hit = (cnt_d >= LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core and a DMA port: core
// priority with a starvation escape, registered one-cycle responses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    output logic              c_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    arb_state_e        state_q, state_d;
    port_sel_e         sel;
    logic              starve_inc, starve_clr, starve_hit;
    logic              g_valid, g_we, g_oor;
    logic [ADDR_W-1:0] g_addr;
    logic [31:0]       g_wdata, g_rdata;
    rsp_t              c_rsp_q, c_rsp_d, d_rsp_q, d_rsp_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // FORCE_D lasts exactly one cycle, granted or not.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (starve_hit) state_d = FORCE_D;
            FORCE_D: state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Held reset blocks every grant, so no memory access can leak out during reset.
    always_comb begin
        sel = SEL_NONE;
        if (reset) begin
            case (state_q)
                ARB: begin
                    if (c_req)      sel = SEL_C;
                    else if (d_req) sel = SEL_D;
                end
                FORCE_D: begin
                    if (d_req)      sel = SEL_D;
                    else if (c_req) sel = SEL_C;
                end
                default: sel = SEL_NONE;
            endcase
        end
    end

    assign c_gnt = (sel == SEL_C);
    assign d_gnt = (sel == SEL_D);

    always_comb begin
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        case (sel)
            SEL_C: begin
                g_we    = c_we;
                g_addr  = c_addr;
                g_wdata = c_wdata;
            end
            SEL_D: begin
                g_we    = d_we;
                g_addr  = d_addr;
                g_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    // Out-of-range accesses are still granted but never reach the memory.
    assign g_valid   = (sel != SEL_NONE);
    assign g_oor     = g_valid && (g_addr >= DEPTH_A);
    assign mem_read  = g_valid && !g_we && !g_oor;
    assign mem_write = g_valid &&  g_we && !g_oor;
    assign mem_addr  = 32'(g_addr);
    assign mem_wdata = g_wdata;
    assign g_rdata   = mem_read ? mem_rdata : '0;

    assign starve_inc = d_req && !d_gnt;
    assign starve_clr = !d_req || d_gnt;

    dmem_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .hit   (starve_hit)
    );

    always_comb begin
        c_rsp_d = '0;
        d_rsp_d = '0;
        if (sel == SEL_C) c_rsp_d = '{valid: 1'b1, err: g_oor, rdata: g_rdata};
        if (sel == SEL_D) d_rsp_d = '{valid: 1'b1, err: g_oor, rdata: g_rdata};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_rsp_q <= '0;
            d_rsp_q <= '0;
        end else begin
            c_rsp_q <= c_rsp_d;
            d_rsp_q <= d_rsp_d;
        end
    end

    assign c_rvalid = c_rsp_q.valid;
    assign c_rdata  = c_rsp_q.rdata;
    assign c_err    = c_rsp_q.err;
    assign d_rvalid = d_rsp_q.valid;
    assign d_rdata  = d_rsp_q.rdata;
    assign d_err    = d_rsp_q.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// long randomized run compared every cycle against a transaction-level model.
module tb_dmem_arbiter;

    localparam int          DEPTH   = 64;
    localparam int          LIMIT   = 4;
    localparam logic [31:0] DEPTH_W = 32'd64;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;

    logic        c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] env_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    // Reference model state: forced-DMA flag, consecutive DMA denials, expected responses.
    bit          m_force;
    int          m_cnt;
    bit          pc_v, pd_v, pc_err, pd_err;
    logic [31:0] pc_rdata, pd_rdata;

    dmem_arbiter #(
        .DEPTH        (DEPTH),
        .ADDR_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .c_err     (c_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory environment: combinational read, write commits at the clock edge.
    assign mem_rdata = (mem_addr < DEPTH_W) ? env_mem[mem_addr[5:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_write && (mem_addr < DEPTH_W)) env_mem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int          win;
        bit          we, oor;
        logic [31:0] ea, ew, rd;
        if (!reset) begin
            check("rst_c_gnt",     32'(c_gnt),     32'd0);
            check("rst_d_gnt",     32'(d_gnt),     32'd0);
            check("rst_mem_read",  32'(mem_read),  32'd0);
            check("rst_mem_write", 32'(mem_write), 32'd0);
            check("rst_mem_addr",  mem_addr,       32'd0);
            check("rst_c_rvalid",  32'(c_rvalid),  32'd0);
            check("rst_d_rvalid",  32'(d_rvalid),  32'd0);
            check("rst_c_rdata",   c_rdata,        32'd0);
            check("rst_d_rdata",   d_rdata,        32'd0);
            check("rst_c_err",     32'(c_err),     32'd0);
            check("rst_d_err",     32'(d_err),     32'd0);
            m_force = 1'b0;
            m_cnt   = 0;
            pc_v    = 1'b0;
            pd_v    = 1'b0;
        end else begin
            check("m_c_rvalid", 32'(c_rvalid), 32'(pc_v));
            if (pc_v) begin
                check("m_c_rdata", c_rdata,     pc_rdata);
                check("m_c_err",   32'(c_err),  32'(pc_err));
            end
            check("m_d_rvalid", 32'(d_rvalid), 32'(pd_v));
            if (pd_v) begin
                check("m_d_rdata", d_rdata,     pd_rdata);
                check("m_d_err",   32'(d_err),  32'(pd_err));
            end

            // 0 = nobody, 1 = core, 2 = DMA
            if (m_force) win = d_req ? 2 : (c_req ? 1 : 0);
            else         win = c_req ? 1 : (d_req ? 2 : 0);

            we = 1'b0; ea = '0; ew = '0;
            if (win == 1) begin we = c_we; ea = c_addr; ew = c_wdata; end
            if (win == 2) begin we = d_we; ea = d_addr; ew = d_wdata; end
            oor = (win != 0) && (ea >= DEPTH_W);

            check("m_c_gnt",     32'(c_gnt),     32'(win == 1));
            check("m_d_gnt",     32'(d_gnt),     32'(win == 2));
            check("m_mem_read",  32'(mem_read),  32'((win != 0) && !we && !oor));
            check("m_mem_write", 32'(mem_write), 32'((win != 0) && we && !oor));
            check("m_mem_addr",  mem_addr,       ea);
            check("m_mem_wdata", mem_wdata,      ew);

            rd = ((win == 0) || we || oor) ? 32'd0 : ref_mem[ea[5:0]];
            pc_v = (win == 1); pc_rdata = rd; pc_err = oor;
            pd_v = (win == 2); pd_rdata = rd; pd_err = oor;
            if ((win != 0) && we && !oor) ref_mem[ea[5:0]] = ew;

            if (d_req && (win != 2)) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            else                     m_cnt = 0;
            m_force = !m_force && (m_cnt >= LIMIT);
        end
    end

    task automatic drive(input bit rn,
                         input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        reset = rn;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // n cycles of core+DMA reads; the DMA must win only at index d_at.
    task automatic contend(input string name, input int n, input int d_at);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(40 + i), 32'd0, 1'b1, 1'b0, 32'(50 + i), 32'd0);
            check({name, "_d_gnt"}, 32'(d_gnt), 32'(i == d_at));
            check({name, "_c_gnt"}, 32'(c_gnt), 32'(i != d_at));
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k = $urandom_range(0, 19);
        if (k == 0) return 32'(64 + $urandom_range(0, 15));
        if (k == 1) return $urandom | 32'h8000_0000;
        if (k < 10) return 32'($urandom_range(0, 7));
        return 32'($urandom_range(0, 63));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = 32'h1000_0000 + 32'(i * 7);
            ref_mem[i] = 32'h1000_0000 + 32'(i * 7);
        end
        env_mem[10] = 32'h45;
        ref_mem[10] = 32'h45;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

        // Reset held with requests present: nothing may be granted.
        drive(1'b0, 1'b1, 1'b1, 32'd3, 32'hFFFF, 1'b1, 1'b1, 32'd4, 32'hEEEE);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Core read of addr 10.
        drive(1'b1, 1'b1, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("rd10_c_gnt",    32'(c_gnt),    32'd1);
        check("rd10_mem_read", 32'(mem_read), 32'd1);
        idle();
        check("rd10_c_rvalid", 32'(c_rvalid), 32'd1);
        check("rd10_c_rdata",  c_rdata,       32'h45);
        check("rd10_c_err",    32'(c_err),    32'd0);

        // Contention: C,C,C,C,D,C,C,C,C,D.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(20 + i), 32'd0, 1'b1, 1'b0, 32'(30 + i), 32'd0);
            check("cont_d_gnt", 32'(d_gnt), 32'((i == 4) || (i == 9)));
            check("cont_c_gnt", 32'(c_gnt), 32'(!((i == 4) || (i == 9))));
            check("cont_d_rvalid", 32'(d_rvalid), 32'(i == 5));
            if (i == 5) check("cont_d_rdata", d_rdata, 32'h1000_00EE);
        end
        idle();
        check("cont_d_rvalid_last", 32'(d_rvalid), 32'd1);

        // DMA write then core read of the same address.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
        check("wr5_d_gnt",     32'(d_gnt),     32'd1);
        check("wr5_mem_write", 32'(mem_write), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("wr5_d_rvalid", 32'(d_rvalid), 32'd1);
        check("wr5_d_rdata",  d_rdata,       32'd0);
        idle();
        check("rd5_c_rdata",  c_rdata,       32'hDEAD_BEEF);

        // Out-of-range core read.
        drive(1'b1, 1'b1, 1'b0, 32'd64, 32'h1234, 1'b0, 1'b0, 32'd0, 32'd0);
        check("oor_c_gnt",    32'(c_gnt),    32'd1);
        check("oor_mem_read", 32'(mem_read), 32'd0);
        idle();
        check("oor_c_rvalid", 32'(c_rvalid), 32'd1);
        check("oor_c_err",    32'(c_err),    32'd1);
        check("oor_c_rdata",  c_rdata,       32'd0);

        // Reset the cycle after a DMA grant: its response is dropped.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd7, 32'd0);
        check("rb_d_gnt", 32'(d_gnt), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 32'd3, 32'hFFFF, 1'b1, 1'b0, 32'd7, 32'd0);
        check("rb_d_rvalid",   32'(d_rvalid),  32'd0);
        check("rb_mem_write",  32'(mem_write), 32'd0);
        contend("rb_post", 5, 4);

        // Counter partly built up, then reset: it must restart from zero.
        contend("pre_rst", 3, -1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        contend("ctr_rst", 5, 4);

        // Reach FORCE_D, then drop d_req: core wins, FSM and counter restart.
        contend("fz_pre", 4, -1);
        drive(1'b1, 1'b1, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("fz_c_gnt", 32'(c_gnt), 32'd1);
        check("fz_d_gnt", 32'(d_gnt), 32'd0);
        contend("fz_post", 5, 4);

        // Randomized traffic, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            bit          rn, cr, cw, dr, dw;
            logic [31:0] ca, cd, da, dd;
            rn = ($urandom_range(0, 199) != 0);
            cr = ($urandom_range(0, 3) != 0);
            cw = ($urandom_range(0, 1) != 0);
            dr = ($urandom_range(0, 2) != 0);
            dw = ($urandom_range(0, 1) != 0);
            ca = rand_addr();
            da = rand_addr();
            cd = $urandom;
            dd = $urandom;
            drive(rn, cr, cw, ca, cd, dr, dw, da, dd);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
